// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Round-robin arbiter and sequencer sharing one SPI master among NUM_REQ
// on-chip requesters. It grants one requester at a time and drives that
// requester's active-low chip select with CS_SETUP_CYCLES of setup before the
// master is launched and CS_HOLD_CYCLES of hold after completion. It then
// returns the received word with a one-cycle acknowledge.
//
// Optional build macro: SPI_ARB_TIMEOUT_EN
//   Defined:   a watchdog aborts WAIT after TIMEOUT_CYCLES without completion.
//              The transfer then finishes with rsp_data = 0 and rsp_err = 1.
//   Undefined: no watchdog is built, rsp_err is tied low and WAIT is unbounded.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   req              per-requester transfer request (level)
//   req_data         tx words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack              one-cycle completion pulse to the granted requester
//   rsp_data         received word, valid with ack, held until the next ack
//   rsp_err          timeout flag, valid with ack
//   cs_n             active-low chip selects, at most one low
//   busy             high in every state except IDLE
//   start_master     one-cycle launch pulse to the SPI master
//   data_master_in   tx word to the SPI master, stable from grant to DONE
//   finish_master    master completion; its rising edge marks completion
//   data_master_out  rx word from the SPI master
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [NUM_REQ-1:0]            cs_n,
    output logic                          busy,
    output logic                          start_master,
    output logic [DATA_WIDTH-1:0]         data_master_in,
    input  logic                          finish_master,
    input  logic [DATA_WIDTH-1:0]         data_master_out
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CS_SETUP_CYCLES < 1 || CS_HOLD_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_master_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       grant;
    logic [CNT_W-1:0]       cnt;
    logic                   finish_d;
    logic                   finish_rise;
    logic [DATA_WIDTH-1:0]  rx;

    logic                   sel_valid;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W:0]         cand;

    // A level already high when WAIT is entered is not a completion: finish_d
    // tracks finish_master in every state, so only a fresh 0->1 edge counts.
    assign finish_rise = finish_master & ~finish_d;

    // Round-robin pick: the first set req bit at or above ptr, wrapping.
    // Scanning from the far end down lets the nearest candidate win last.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it holding its old value, which would infer a latch.
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd;
    logic            err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state          <= S_IDLE;
            ptr            <= '0;
            grant          <= '0;
            cnt            <= '0;
            finish_d       <= 1'b0;
            rx             <= '0;
            cs_n           <= '1;
            ack            <= '0;
            rsp_data       <= '0;
            busy           <= 1'b0;
            start_master   <= 1'b0;
            data_master_in <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd             <= '0;
            err            <= 1'b0;
            rsp_err        <= 1'b0;
`endif
        end else begin
            finish_d <= finish_master;
            ack      <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        grant          <= sel_idx;
                        data_master_in <= req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                        cs_n           <= ~(NUM_REQ'(1) << sel_idx);
                        cnt            <= CNT_W'(CS_SETUP_CYCLES);
                        busy           <= 1'b1;
                        state          <= S_SETUP;
                    end
                end
                // The counter is loaded with the cycle count and leaves at 1,
                // so SETUP lasts exactly CS_SETUP_CYCLES cycles.
                S_SETUP: begin
                    if (cnt == CNT_W'(1)) begin
                        start_master <= 1'b1;
                        state        <= S_START;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_START: begin
                    start_master <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    wd           <= '0;
`endif
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (finish_rise) begin
                        rx    <= data_master_out;
                        cnt   <= CNT_W'(CS_HOLD_CYCLES);
`ifdef SPI_ARB_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                        state <= S_HOLD;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rx    <= '0;
                        err   <= 1'b1;
                        cnt   <= CNT_W'(CS_HOLD_CYCLES);
                        state <= S_HOLD;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (cnt == CNT_W'(1)) begin
                        cs_n     <= '1;
                        ack      <= NUM_REQ'(1) << grant;
                        rsp_data <= rx;
`ifdef SPI_ARB_TIMEOUT_EN
                        rsp_err  <= err;
`endif
                        ptr      <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // Requests seen here are ignored; the earliest next grant is
                // decided in IDLE, giving the cs_n high gap.
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef SPI_ARB_TIMEOUT_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Self-checking bench for spi_master_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// CS_SETUP_CYCLES=2, CS_HOLD_CYCLES=2, TIMEOUT_CYCLES=16). The SPI master is
// modelled by the bench, which raises finish_master after a chosen delay with
// a chosen rx word. Grant order comes from a pending-request set and a
// round-robin pointer kept by the bench. With SPI_ARB_TIMEOUT_EN defined the
// watchdog scenario is also exercised.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int SETUP   = 2;
    localparam int HOLD    = 2;
    localparam int TMO     = 16;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     ack;
    logic [DW-1:0]          rsp_data;
    logic                   rsp_err;
    logic [NUM_REQ-1:0]     cs_n;
    logic                   busy;
    logic                   start_master;
    logic [DW-1:0]          data_master_in;
    logic                   finish_master;
    logic [DW-1:0]          data_master_out;

    int vectors     = 0;
    int miscompares = 0;
    int multi_cs    = 0;
    int ack_count   = 0;

    spi_master_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .DATA_WIDTH      (DW),
        .CS_SETUP_CYCLES (SETUP),
        .CS_HOLD_CYCLES  (HOLD),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_data        (req_data),
        .ack             (ack),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .cs_n            (cs_n),
        .busy            (busy),
        .start_master    (start_master),
        .data_master_in  (data_master_in),
        .finish_master   (finish_master),
        .data_master_out (data_master_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive observers: chip-select exclusivity and acknowledge count.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ($countones(~cs_n) > 1) multi_cs++;
            if (ack !== '0) ack_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    task automatic do_reset;
        rst_n           = 1'b0;
        req             = '0;
        finish_master   = 1'b0;
        data_master_out = '0;
        req_data        = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete transfer for requester g, acting as the SPI master.
    // gap returns the number of cycles cs_n stayed all-high before the grant.
    task automatic serve_one(input int g, input logic [DW-1:0] exp_tx, input logic [DW-1:0] rsp,
                             input int delay, input bit drop_on_ack, input bit early_drop,
                             input bit stale, output int gap);
        int                 n;
        bit                 saw_ack;
        logic [NUM_REQ-1:0] exp_cs;
        logic [NUM_REQ-1:0] exp_ack;
        exp_ack = NUM_REQ'(1) << g;
        exp_cs  = ~exp_ack;
        gap     = 0;
        while (cs_n === '1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        vectors++;
        if (cs_n !== exp_cs) begin
            miscompares++;
            $display("FAIL grant_cs: cs_n=%b, required %b", cs_n, exp_cs);
            return;
        end
        vectors++;
        if (data_master_in !== exp_tx || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_data: data_master_in=%h busy=%b, required %h busy=1",
                     data_master_in, busy, exp_tx);
        end
        // The word must have been latched at grant, not followed afterwards.
        for (int w = 0; w < NUM_REQ; w++) req_data[w*DW +: DW] = DW'($urandom);
        n = 0;
        while (start_master !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (early_drop && n == 1) req[g] = 1'b0;
        end
        vectors++;
        if (n != SETUP) begin
            miscompares++;
            $display("FAIL start_latency: %0d cycles after cs_n fall, required %0d", n, SETUP);
        end
        @(negedge clk);
        vectors++;
        if (start_master !== 1'b0) begin
            miscompares++;
            $display("FAIL start_width: start_master=%b one cycle later, required 0", start_master);
        end
        if (stale) begin
            saw_ack = 1'b0;
            repeat (delay) begin
                @(negedge clk);
                if (ack !== '0) saw_ack = 1'b1;
            end
            vectors++;
            if (saw_ack || cs_n !== exp_cs) begin
                miscompares++;
                $display("FAIL stale_level: ack seen=%b cs_n=%b, required no ack and cs_n %b",
                         saw_ack, cs_n, exp_cs);
            end
            finish_master = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (delay) @(negedge clk);
        end
        data_master_out = rsp;
        finish_master   = 1'b1;
        @(negedge clk);
        finish_master   = 1'b0;
        data_master_out = ~rsp;
        n = 0;
        while (ack === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != HOLD) begin
            miscompares++;
            $display("FAIL hold_latency: ack %0d cycles after completion, required %0d", n, HOLD);
        end
        vectors++;
        if (ack !== exp_ack || rsp_data !== rsp || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_rsp: ack=%b rsp_data=%h rsp_err=%b, required ack=%b rsp_data=%h rsp_err=0",
                     ack, rsp_data, rsp_err, exp_ack, rsp);
        end
        vectors++;
        if (cs_n !== '1 || data_master_in !== exp_tx) begin
            miscompares++;
            $display("FAIL done_state: cs_n=%b data_master_in=%h, required 1111 and %h",
                     cs_n, data_master_in, exp_tx);
        end
        if (drop_on_ack) req[g] = 1'b0;
        @(negedge clk);
        vectors++;
        if (ack !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_width: ack=%b busy=%b after DONE, required 0000 and 0", ack, busy);
        end
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        req             = '0;
        req_data        = '0;
        finish_master   = 1'b0;
        data_master_out = '0;
        #12;
        vectors++;
        if (cs_n !== '1 || ack !== '0 || busy !== 1'b0 || start_master !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: cs_n=%b ack=%b busy=%b start=%b, required 1111 0000 0 0",
                     cs_n, ack, busy, start_master);
        end
        vectors++;
        if (rsp_data !== '0 || rsp_err !== 1'b0 || data_master_in !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rsp_data=%h rsp_err=%b data_master_in=%h, required 00 0 00",
                     rsp_data, rsp_err, data_master_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int gap;
        do_reset();
        req_data[1*DW +: DW] = 8'hA5;
        req = 4'b0010;
        serve_one(1, 8'hA5, 8'h3C, 3, 1'b1, 1'b0, 1'b0, gap);
        vectors++;
        if (gap != 1) begin
            miscompares++;
            $display("FAIL single_latency: cs_n fell %0d cycles after req, required 1", gap);
        end
    endtask

    task automatic test_contention;
        int             gap;
        int             order[4] = '{0, 1, 3, 0};
        logic [DW-1:0]  tx;
        do_reset();
        multi_cs = 0;
        for (int w = 0; w < NUM_REQ; w++) req_data[w*DW +: DW] = DW'($urandom);
        req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tx = req_data[order[i]*DW +: DW];
            serve_one(order[i], tx, DW'($urandom), int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0, gap);
            if (i > 0) begin
                vectors++;
                if (gap < 1) begin
                    miscompares++;
                    $display("FAIL contention_gap: %0d all-high cycles, required at least 1", gap);
                end
            end
        end
        req = '0;
        repeat (4) @(negedge clk);
        vectors++;
        if (multi_cs != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_cs: %0d multi-low cycles busy=%b, required 0 and 0", multi_cs, busy);
        end
    endtask

    task automatic test_early_release;
        int gap;
        int low_cycles;
        do_reset();
        req_data[2*DW +: DW] = 8'h5E;
        req = 4'b0100;
        serve_one(2, 8'h5E, 8'hC7, 4, 1'b1, 1'b1, 1'b0, gap);
        low_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (cs_n !== '1) low_cycles++;
        end
        vectors++;
        if (low_cycles != 0) begin
            miscompares++;
            $display("FAIL early_release_regrant: cs_n low in %0d cycles, required 0", low_cycles);
        end
    endtask

    task automatic test_stale_finish;
        int gap;
        int base;
        do_reset();
        finish_master = 1'b1;
        @(negedge clk);
        req_data[0] = 1'b1;
        req_data[DW-1:1] = 7'h2B;
        req  = 4'b0001;
        base = ack_count;
        serve_one(0, {7'h2B, 1'b1}, 8'h91, 4, 1'b1, 1'b0, 1'b1, gap);
        repeat (5) @(negedge clk);
        vectors++;
        if (ack_count - base != 1) begin
            miscompares++;
            $display("FAIL stale_ack_count: %0d acks, required 1", ack_count - base);
        end
    endtask

    task automatic test_reset_mid;
        int gap;
        int n;
        int base;
        do_reset();
        req_data = 32'h44_33_22_11;
        req = 4'b0010;
        serve_one(1, 8'h22, 8'h6D, 1, 1'b1, 1'b0, 1'b0, gap);
        req = 4'b0100;
        n = 0;
        while (start_master !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        base = ack_count;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (cs_n !== '1 || busy !== 1'b0 || start_master !== 1'b0 || ack !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: cs_n=%b busy=%b start=%b ack=%b, required 1111 0 0 0000",
                     cs_n, busy, start_master, ack);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (ack_count != base) begin
            miscompares++;
            $display("FAIL reset_mid_ack: %0d acks after reset, required 0", ack_count - base);
        end
        req_data = 32'h88_77_66_55;
        req = 4'b0101;
        serve_one(0, 8'h55, 8'hE2, 2, 1'b1, 1'b0, 1'b0, gap);
        req_data[2*DW +: DW] = 8'h77;
        serve_one(2, 8'h77, 8'h19, 0, 1'b1, 1'b0, 1'b0, gap);
    endtask

    // Randomised traffic: requests accumulate in a pending set and the bench
    // predicts each grant from the round-robin rule.
    task automatic test_random;
        logic [NUM_REQ-1:0] pending;
        logic [DW-1:0]      tx;
        logic [DW-1:0]      rsp;
        int                 ptr_m;
        int                 g;
        int                 gap;
        do_reset();
        pending = '0;
        ptr_m   = 0;
        for (int r = 0; r < 40; r++) begin
            pending = pending | NUM_REQ'($urandom);
            if (pending == '0) pending[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
            for (int w = 0; w < NUM_REQ; w++) req_data[w*DW +: DW] = DW'($urandom);
            req = pending;
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && pending[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
            end
            tx  = req_data[g*DW +: DW];
            rsp = DW'($urandom);
            serve_one(g, tx, rsp, int'($urandom_range(0, 6)), 1'b1, 1'b0, 1'b0, gap);
            pending[g] = 1'b0;
            ptr_m      = (g + 1) % NUM_REQ;
        end
        req = '0;
        @(negedge clk);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int gap;
        int n;
        do_reset();
        req_data[0 +: DW] = 8'h0F;
        req = 4'b0001;
        serve_one(0, 8'h0F, 8'h5A, 1, 1'b1, 1'b0, 1'b0, gap);
        req_data[3*DW +: DW] = 8'hB4;
        req = 4'b1000;
        n = 0;
        while (start_master !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ack === '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 1 + TMO + HOLD) begin
            miscompares++;
            $display("FAIL timeout_latency: ack %0d cycles after start, required %0d", n, 1 + TMO + HOLD);
        end
        vectors++;
        if (ack !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
            miscompares++;
            $display("FAIL timeout_rsp: ack=%b rsp_err=%b rsp_data=%h, required 1000 1 00",
                     ack, rsp_err, rsp_data);
        end
        req = '0;
        @(negedge clk);
        req_data[0 +: DW] = 8'h3D;
        req = 4'b0001;
        serve_one(0, 8'h3D, 8'hA7, 2, 1'b1, 1'b0, 1'b0, gap);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_stale_finish();
        test_reset_mid();
        test_random();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
